// File: rtl/pcs_sync_multilane.sv
// Multi-lane 1000BASE-X style receive synchronisation: per-lane comma alignment
// and loss-of-sync hysteresis, plus a combined sync flag and sync-loss counter.
//   state          | meaning
//   LOSS_OF_SYNC   | hunting for a comma to fix the even/odd phase
//   COMMA_DETECT   | phase fixed, counting further even commas (C)
//   SYNC_ACQUIRED  | in sync, tracking bad level (L) and good run (G)
module pcs_sync_multilane #(
  parameter int LANES  = 4,
  parameter int NCOMMA = 3,
  parameter int NBAD   = 4,
  parameter int NGOOD  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [10*LANES-1:0]   rx_code_group,
  input  logic [LANES-1:0]      rx_cg_err,
  output logic [10*LANES-1:0]   rx_code_group_out,
  output logic [LANES-1:0]      rx_even,
  output logic [LANES-1:0]      sync_status,
  output logic                  all_sync,
  output logic [7:0]            loss_count
);

  typedef enum logic [1:0] {
    LOSS_OF_SYNC  = 2'd0,
    COMMA_DETECT  = 2'd1,
    SYNC_ACQUIRED = 2'd2
  } state_e;

  localparam logic [2:0] NCOMMA_C = 3'(NCOMMA);
  localparam logic [2:0] NBAD_C   = 3'(NBAD);
  localparam logic [3:0] NGOOD_C  = 4'(NGOOD);

  logic [LANES-1:0] lost;
  logic [7:0]       loss_q, loss_d;
  logic [8:0]       loss_sum;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    state_e     state_q, state_d;
    logic [2:0] c_q, c_d, l_q, l_d;
    logic [3:0] g_q, g_d;
    logic       e_q, e_d;
    logic [9:0] cg, cg_q;
    logic       comma, cgbad, lost_k;

    assign cg    = rx_code_group[10*k +: 10];
    assign comma = (cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000);
    // e_q==1 means the previous group was labelled even, so this one is odd
    assign cgbad = rx_cg_err[k] | (comma & e_q);

    always_comb begin
      state_d = state_q;
      c_d     = c_q;
      l_d     = l_q;
      g_d     = g_q;
      lost_k  = 1'b0;
      e_d     = (state_q == LOSS_OF_SYNC && comma) ? 1'b1 : ~e_q;
      case (state_q)
        LOSS_OF_SYNC: begin
          if (comma && !rx_cg_err[k]) begin
            if (NCOMMA_C == 3'd1) begin
              state_d = SYNC_ACQUIRED;
              l_d     = 3'd0;
              g_d     = 4'd0;
            end else begin
              state_d = COMMA_DETECT;
              c_d     = 3'd1;
            end
          end
        end
        COMMA_DETECT: begin
          if (cgbad) begin
            state_d = LOSS_OF_SYNC;
            c_d     = 3'd0;
          end else if (comma) begin
            if (c_q + 3'd1 == NCOMMA_C) begin
              state_d = SYNC_ACQUIRED;
              c_d     = 3'd0;
              l_d     = 3'd0;
              g_d     = 4'd0;
            end else begin
              c_d = c_q + 3'd1;
            end
          end
        end
        SYNC_ACQUIRED: begin
          if (cgbad) begin
            g_d = 4'd0;
            if (l_q == NBAD_C - 3'd1) begin
              state_d = LOSS_OF_SYNC;
              l_d     = 3'd0;
              lost_k  = 1'b1;
            end else begin
              l_d = l_q + 3'd1;
            end
          end else if (l_q != 3'd0) begin
            if (g_q + 4'd1 == NGOOD_C) begin
              l_d = l_q - 3'd1;
              g_d = 4'd0;
            end else begin
              g_d = g_q + 4'd1;
            end
          end else begin
            g_d = 4'd0;
          end
        end
        default: state_d = LOSS_OF_SYNC;
      endcase
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= LOSS_OF_SYNC;
        c_q     <= 3'd0;
        l_q     <= 3'd0;
        g_q     <= 4'd0;
        e_q     <= 1'b0;
        cg_q    <= 10'd0;
      end else begin
        state_q <= state_d;
        c_q     <= c_d;
        l_q     <= l_d;
        g_q     <= g_d;
        e_q     <= e_d;
        cg_q    <= cg;
      end
    end

    assign lost[k]                   = lost_k;
    assign rx_code_group_out[10*k +: 10] = cg_q;
    assign rx_even[k]                = e_q;
    assign sync_status[k]            = (state_q == SYNC_ACQUIRED);
  end

  always_comb begin
    loss_sum = {1'b0, loss_q};
    for (int i = 0; i < LANES; i++) begin
      loss_sum = loss_sum + 9'(lost[i]);
    end
    loss_d = (loss_sum > 9'd255) ? 8'hFF : loss_sum[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) loss_q <= 8'd0;
    else       loss_q <= loss_d;
  end

  assign loss_count = loss_q;
  assign all_sync   = &sync_status;

endmodule

// File: tb/tb_pcs_sync_multilane.sv
// Bench for pcs_sync_multilane: directed scenarios plus random traffic, all
// compared against a behavioural per-lane sync model.
module tb_pcs_sync_multilane;
  localparam int LANES  = 4;
  localparam int NCOMMA = 3;
  localparam int NBAD   = 4;
  localparam int NGOOD  = 4;
  localparam logic [9:0] K28_5P = 10'b0011111010;
  localparam logic [9:0] K28_5N = 10'b1100000101;

  logic                clock = 1'b0;
  logic                reset;
  logic [10*LANES-1:0] rx_code_group;
  logic [LANES-1:0]    rx_cg_err;
  logic [10*LANES-1:0] rx_code_group_out;
  logic [LANES-1:0]    rx_even;
  logic [LANES-1:0]    sync_status;
  logic                all_sync;
  logic [7:0]          loss_count;

  int errors = 0;
  int checks = 0;

  // model: 0 = hunting, 1 = counting commas, 2 = in sync
  int              m_st  [LANES];
  int              m_c   [LANES];
  int              m_l   [LANES];
  int              m_g   [LANES];
  bit              m_e   [LANES];
  logic [10*LANES-1:0] m_out;
  int              m_loss;

  always #5 clock = ~clock;

  pcs_sync_multilane #(.LANES(LANES), .NCOMMA(NCOMMA), .NBAD(NBAD), .NGOOD(NGOOD)) dut (
    .clock             (clock),
    .reset             (reset),
    .rx_code_group     (rx_code_group),
    .rx_cg_err         (rx_cg_err),
    .rx_code_group_out (rx_code_group_out),
    .rx_even           (rx_even),
    .sync_status       (sync_status),
    .all_sync          (all_sync),
    .loss_count        (loss_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_comma(input logic [9:0] g);
    return (g[9:3] == 7'b0011111) || (g[9:3] == 7'b1100000);
  endfunction

  function automatic logic [9:0] dgroup();
    logic [9:0] v;
    v = 10'($urandom);
    if (is_comma(v)) v[9] = ~v[9];
    return v;
  endfunction

  function automatic logic [10*LANES-1:0] build(input logic [LANES-1:0] commas);
    logic [10*LANES-1:0] v;
    for (int k = 0; k < LANES; k++)
      v[10*k +: 10] = commas[k] ? (($urandom_range(0, 1) != 0) ? K28_5P : K28_5N) : dgroup();
    return v;
  endfunction

  task automatic model_step(input bit rst, input logic [10*LANES-1:0] cg, input logic [LANES-1:0] err);
    int drops;
    drops = 0;
    if (rst) begin
      for (int k = 0; k < LANES; k++) begin
        m_st[k] = 0; m_c[k] = 0; m_l[k] = 0; m_g[k] = 0; m_e[k] = 0;
      end
      m_out  = '0;
      m_loss = 0;
      return;
    end
    for (int k = 0; k < LANES; k++) begin
      bit cm, bad, hunting;
      cm      = is_comma(cg[10*k +: 10]);
      bad     = err[k] || (cm && m_e[k]);
      hunting = (m_st[k] == 0);
      if (m_st[k] == 0) begin
        if (cm && !err[k]) begin
          m_st[k] = (NCOMMA == 1) ? 2 : 1;
          m_c[k] = 1; m_l[k] = 0; m_g[k] = 0;
        end
      end else if (m_st[k] == 1) begin
        if (bad) m_st[k] = 0;
        else if (cm) begin
          m_c[k]++;
          if (m_c[k] == NCOMMA) begin m_st[k] = 2; m_l[k] = 0; m_g[k] = 0; end
        end
      end else begin
        if (bad) begin
          if (m_l[k] == NBAD - 1) begin m_st[k] = 0; drops++; end
          else begin m_l[k]++; m_g[k] = 0; end
        end else if (m_l[k] > 0) begin
          m_g[k]++;
          if (m_g[k] == NGOOD) begin m_l[k]--; m_g[k] = 0; end
        end
      end
      m_e[k] = (hunting && cm) ? 1'b1 : !m_e[k];
    end
    m_out  = cg;
    m_loss = (m_loss + drops > 255) ? 255 : m_loss + drops;
  endtask

  task automatic cycle(input bit rst, input logic [10*LANES-1:0] cg, input logic [LANES-1:0] err);
    logic [LANES-1:0] es, ee;
    reset         = rst;
    rx_code_group = cg;
    rx_cg_err     = err;
    @(posedge clock);
    model_step(rst, cg, err);
    #1;
    for (int k = 0; k < LANES; k++) begin
      es[k] = (m_st[k] == 2);
      ee[k] = m_e[k];
    end
    check("sync_status", sync_status, es);
    check("all_sync", all_sync, &es);
    check("loss_count", loss_count, m_loss);
    check("cg_out", rx_code_group_out, m_out);
    check("rx_even", rx_even, ee);
  endtask

  task automatic acquire(input logic [LANES-1:0] lanes);
    for (int i = 0; i < 5; i++)
      cycle(1'b0, build((i % 2 == 0) ? lanes : '0), '0);
  endtask

  initial begin
    int rate;
    reset = 1'b1; rx_code_group = '0; rx_cg_err = '0;
    cycle(1'b1, build('0), '0);
    cycle(1'b1, build('0), '0);
    check("rst_out", rx_code_group_out, 0);
    check("rst_sync", sync_status, 0);

    // lane 0 commas at 0,2,4
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, build((i % 2 == 0 && i <= 4) ? 4'b0001 : 4'b0000), '0);
      if (i == 3) check("acq_early", sync_status, 4'b0000);
      if (i == 4) check("acq_done", sync_status, 4'b0001);
    end
    check("acq_all_sync", all_sync, 0);

    // four spaced errors with too few good groups between
    begin
      bit pat [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
      for (int i = 0; i < 8; i++) begin
        cycle(1'b0, build('0), {3'b000, pat[i]});
        if (i == 6) check("bad_hold", sync_status[0], 1);
      end
      check("bad_drop", sync_status[0], 0);
      check("bad_loss", loss_count, 1);
    end

    // one error recovered by four good, then three errors keep sync
    cycle(1'b1, build('0), '0);
    acquire(4'b0001);
    begin
      bit pat [8] = '{1, 0, 0, 0, 0, 1, 1, 1};
      for (int i = 0; i < 8; i++) cycle(1'b0, build('0), {3'b000, pat[i]});
    end
    check("hyst_hold", sync_status[0], 1);
    cycle(1'b0, build('0), 4'b0001);
    check("hyst_drop", sync_status[0], 0);
    check("hyst_loss", loss_count, 1);

    // comma one cycle after the first comma is odd
    cycle(1'b1, build('0), '0);
    cycle(1'b0, build(4'b0001), '0);
    cycle(1'b0, build(4'b0001), '0);
    for (int i = 0; i < 4; i++) cycle(1'b0, build((i % 2 == 1) ? 4'b0001 : 4'b0000), '0);
    check("odd_comma", sync_status[0], 0);

    // all lanes lose sync together; repeat into saturation
    cycle(1'b1, build('0), '0);
    for (int r = 0; r < 66; r++) begin
      acquire(4'b1111);
      if (r == 0) check("all_acq", all_sync, 1);
      for (int i = 0; i < 4; i++) cycle(1'b0, build('0), 4'b1111);
      if (r == 0) check("loss_plus4", loss_count, 4);
    end
    check("loss_sat", loss_count, 255);

    // reset while three lanes are in sync
    cycle(1'b1, build('0), '0);
    acquire(4'b0111);
    check("three_sync", sync_status, 4'b0111);
    cycle(1'b1, build(4'b1111), 4'b1010);
    check("rst_mid_out", rx_code_group_out, 0);
    check("rst_mid_even", rx_even, 0);
    check("rst_mid_sync", sync_status, 0);
    check("rst_mid_all", all_sync, 0);
    check("rst_mid_loss", loss_count, 0);

    // random traffic with varying error rates
    for (int n = 0; n < 3000; n++) begin
      logic [LANES-1:0] cm, er;
      rate = (n / 500) % 3 == 0 ? 2 : ((n / 500) % 3 == 1 ? 8 : 20);
      for (int k = 0; k < LANES; k++) begin
        cm[k] = (((n + k) % 2 == 0) && $urandom_range(0, 1) == 1) || ($urandom_range(0, 39) == 0);
        er[k] = ($urandom_range(0, 99) < rate);
      end
      cycle($urandom_range(0, 499) == 0, build(cm), er);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
